mem_burst_arbiter: RTL
======================

Name: mem_burst_arbiter

Overview:
- Parametrised, multi-channel memory access unit. NUM_CH requesters (kernel, picture, later more) share one synchronous word-addressed memory port.
- Each request fetches BURST consecutive DATA_W-bit words and returns them packed into one wide word.
- Round-robin arbitration between channels. All sequencing is paced by the CLK_MEM enable strobe.
- Sits between the pipeline's memory stage and the unified data memory. Replaces per-memory controller pairs.

Parameters:
- NUM_CH, 2, number of requesting channels (1..8)
- DATA_W, 16, memory word width
- ADDR_W, 32, word-address width
- BURST, 3, words fetched per request (1..8)
- CNT_W, 16, width of per-channel statistics counters (MEM_STATS_EN only)

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- CLK_MEM  in  1  memory tick enable; state advances only on CLK edges where CLK_MEM=1
- REQ  in  NUM_CH  per-channel request level
- ADDRESS  in  NUM_CH*ADDR_W  per-channel start word address; channel c at [c*ADDR_W +: ADDR_W]
- GRANT  out  NUM_CH  one-hot channel currently being served
- BUSY  out  1  burst in progress
- DONE  out  NUM_CH  one-CLK-cycle pulse on the served channel's bit when READ is complete
- READ  out  BURST*DATA_W  packed burst; word i at [i*DATA_W +: DATA_W]
- MEM_ADDRESS  out  ADDR_W  address to memory
- MEM_READ  in  DATA_W  memory data, registered read, 1-tick latency
- BURST_COUNT  out  NUM_CH*CNT_W  completed bursts per channel (MEM_STATS_EN only)

Behaviour:
- Reset: state IDLE; GRANT=0, BUSY=0, DONE=0, READ=0, MEM_ADDRESS=0; RR pointer=NUM_CH-1, so channel 0 has first priority; BURST_COUNT=0.
- Tick = CLK edge with CLK_MEM=1. Non-tick edges hold all state, except that the DONE pulse clears on the next CLK edge regardless of CLK_MEM.
- FSM states: IDLE, FETCH.
- IDLE, tick, any REQ set:
  - Pick first requesting channel after the RR pointer (cyclic). Set GRANT, BUSY=1, MEM_ADDRESS=ADDRESS[g], idx=0, go to FETCH.
  - ADDRESS[g] is latched internally at this tick; later changes are ignored.
- IDLE, no REQ: stay; outputs hold. READ keeps the last completed burst.
- FETCH, each tick k (k=1..BURST):
  - READ word k-1 <= MEM_READ.
  - MEM_ADDRESS <= start+k, modulo 2^ADDR_W, so wrap to 0 is allowed.
- Capture tick for word BURST-1:
  - DONE[g]<=1, GRANT<=0, BUSY<=0, RR pointer<=g, state<=IDLE.
- Latency: DONE asserts BURST ticks after the grant tick. A burst occupies BURST+1 ticks including arbitration. Earliest next grant is the tick after DONE.
- READ is updated word-by-word during FETCH. It is valid only from DONE until the next grant's first capture.
- Requester rules:
  - Hold REQ until DONE.
  - Deassert REQ the cycle after DONE. If REQ is still high at the next IDLE tick, it is a new request.
- REQ dropped mid-burst: the burst still completes and DONE still pulses.
- Simultaneous REQs: exactly one grant per arbitration. With persistent requests, service is strictly fair (c, c+1, ...). NUM_CH=1 degenerates to always granting channel 0.
- RESET mid-burst: abort immediately, return to reset values, no DONE.
- BURST=1: FETCH lasts one tick.

Optional Feature:
- Macro MEM_STATS_EN.
- Defined: BURST_COUNT present. Channel c's counter increments on each DONE[c] and saturates at all-ones. Cleared by RESET.
- Undefined: BURST_COUNT port and counters are absent; no other behaviour changes.

Decomposition:
- Package mem_access_pkg holds:
  - state enum (IDLE, FETCH)
  - default parameter constants
  - idx width function: clog2 of BURST, minimum 1
  - packed-word slice helper
- Natural sub-module rr_arbiter, parametrised by NUM_CH. Inputs: req vector, pointer, enable. Output: one-hot grant plus index. Combinational select with the pointer register kept in the parent.

Test Plan:
- Single burst, memory with mem[a]=a+0x100, CLK_MEM=1 every cycle. REQ[0]=1, ADDRESS0=0x10 -> GRANT=01 at tick 0; DONE[0] after tick 3; READ=0x0112_0111_0110.
- REQ=11 simultaneously, ADDRESS0=0x0, ADDRESS1=0x20, held -> ch0 served first (DONE[0]), then ch1 (DONE[1], READ=0x0122_0121_0120), then ch0 again. Fairness holds.
- CLK_MEM high every 4th cycle -> same READ values. DONE appears 12 CLK cycles after the grant tick and is exactly one CLK wide.
- ADDRESS0=0xFFFFFFFF -> fetched addresses 0xFFFFFFFF, 0x0, 0x1. Packed words match mem at those addresses.
- RESET asserted after the 2nd capture tick -> next cycle BUSY=0, GRANT=0, READ=0, no DONE. A new REQ[1] after reset is granted normally.
- MEM_STATS_EN with CNT_W=2 and 5 bursts on ch1 -> BURST_COUNT[1]=3 (saturated), BURST_COUNT[0]=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants, state encodings and index/slice helpers for the burst memory access unit.
// MEM_STATS_EN adds the default width of the per-channel burst counters.
package mem_access_pkg;

  localparam int unsigned DEF_NUM_CH = 2;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_BURST  = 3;
`ifdef MEM_STATS_EN
  localparam int unsigned DEF_CNT_W  = 16;
`endif

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FETCH = 1'b1;

  // Bits needed to index n items, never less than one.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : 32'($clog2(n));
  endfunction

  // Low bit of item i in a vector packed from w-bit items.
  function automatic int unsigned slice_lo(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/mem_burst_arbiter_rr_arbiter.sv
// Combinational round-robin select: first requester after ptr, cyclically.
// The pointer register lives in the parent.
module rr_arbiter
  import mem_access_pkg::*;
#(
  parameter  int unsigned NUM_CH = DEF_NUM_CH,
  localparam int unsigned PW     = idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PW-1:0]     ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] grant_c,
  output logic [PW-1:0]     idx_c,
  output logic              valid_c
);

  int unsigned cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    cand    = 0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = (32'(ptr) + i) % NUM_CH;
      if (en && !valid_c && req[PW'(cand)]) begin
        valid_c             = 1'b1;
        grant_c[PW'(cand)]  = 1'b1;
        idx_c               = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_burst_arbiter.sv
// Round-robin multi-channel burst reader on one word-addressed memory port, paced by CLK_MEM.
// Define MEM_STATS_EN to add saturating per-channel completed-burst counters (BURST_COUNT).
module mem_burst_arbiter
  import mem_access_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned BURST  = DEF_BURST
`ifdef MEM_STATS_EN
  ,
  parameter int unsigned CNT_W  = DEF_CNT_W
`endif
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       CLK_MEM,
  input  logic [NUM_CH-1:0]          REQ,
  input  logic [NUM_CH*ADDR_W-1:0]   ADDRESS,
  output logic [NUM_CH-1:0]          GRANT,
  output logic                       BUSY,
  output logic [NUM_CH-1:0]          DONE,
  output logic [BURST*DATA_W-1:0]    READ,
  output logic [ADDR_W-1:0]          MEM_ADDRESS,
  input  logic [DATA_W-1:0]          MEM_READ
`ifdef MEM_STATS_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]    BURST_COUNT
`endif
);

  localparam int unsigned PW = idx_w(NUM_CH);
  localparam int unsigned IW = idx_w(BURST);
  localparam int unsigned RW = BURST * DATA_W;

  logic [0:0]        state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic              busy_q, busy_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [RW-1:0]     read_q, read_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [PW-1:0]     ptr_q, ptr_d;

  logic [NUM_CH-1:0] arb_grant_c;
  logic [PW-1:0]     arb_idx_c;
  logic              arb_valid_c;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr_arbiter (
    .req     (REQ),
    .ptr     (ptr_q),
    .en      (CLK_MEM && (state_q == ST_IDLE)),
    .grant_c (arb_grant_c),
    .idx_c   (arb_idx_c),
    .valid_c (arb_valid_c)
  );

  // Next-state: everything holds off-tick except DONE, which is a single CLK-cycle pulse.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    done_d     = '0;
    read_d     = read_q;
    mem_addr_d = mem_addr_q;
    idx_d      = idx_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    if (CLK_MEM) begin
      case (state_q)
        ST_IDLE: begin
          if (arb_valid_c) begin
            grant_d = arb_grant_c;
            gidx_d  = arb_idx_c;
            busy_d  = 1'b1;
            idx_d   = '0;
            state_d = ST_FETCH;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              if (arb_grant_c[c]) mem_addr_d = ADDRESS[slice_lo(c, ADDR_W) +: ADDR_W];
            end
          end
        end
        ST_FETCH: begin
          // MEM_READ holds the word addressed at the previous tick.
          for (int unsigned i = 0; i < BURST; i++) begin
            if (32'(idx_q) == i) read_d[slice_lo(i, DATA_W) +: DATA_W] = MEM_READ;
          end
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          if (32'(idx_q) == BURST - 1) begin
            done_d  = grant_q;
            grant_d = '0;
            busy_d  = 1'b0;
            ptr_d   = gidx_q;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= '0;
      read_q     <= '0;
      mem_addr_q <= '0;
      idx_q      <= '0;
      gidx_q     <= '0;
      ptr_q      <= PW'(NUM_CH - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      read_q     <= read_d;
      mem_addr_q <= mem_addr_d;
      idx_q      <= idx_d;
      gidx_q     <= gidx_d;
      ptr_q      <= ptr_d;
    end
  end

  assign GRANT       = grant_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign READ        = read_q;
  assign MEM_ADDRESS = mem_addr_q;

`ifdef MEM_STATS_EN
  logic [NUM_CH*CNT_W-1:0] cnt_q, cnt_d;

  // Saturating count of completed bursts, bumped on the edge that raises DONE.
  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (done_d[c] && (cnt_q[slice_lo(c, CNT_W) +: CNT_W] != '1))
        cnt_d[slice_lo(c, CNT_W) +: CNT_W] = cnt_q[slice_lo(c, CNT_W) +: CNT_W] + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign BURST_COUNT = cnt_q;
`endif

endmodule
